// File: rtl/definitions_pkg.sv
// Shared definitions for the rv32i multicycle controller.
//   ctrl_state_t : controller state encoding
//   OP_*         : opcode field values (instr[6:0]) decoded in DECODE
//   RES_*        : result_src encodings
//   SRCA_* / SRCB_* : ALU operand select encodings
//   ALUOP_*      : alu_op encodings fed to alu_decoder
package definitions_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/control_fsm.sv
// Multicycle main controller for the rv32i core (Moore FSM).
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath selects and write enables.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   op_i[6:0]           : opcode from the instruction register
//   zero_i              : ALU zero flag (gates pc_write in BEQ)
//   mem_ready_i         : memory access completes this cycle
//   pc_write_o          : PC enable = pc_update | (branch & zero_i)
//   adr_src_o           : memory address select (0 PC, 1 Result)
//   mem_write_o         : memory write strobe
//   ir_write_o          : instruction register / OldPC enable
//   reg_write_o         : register file write enable
//   result_src_o[1:0]   : result select
//   alu_src_a_o[1:0]    : ALU A select
//   alu_src_b_o[1:0]    : ALU B select
//   alu_op_o[1:0]       : to alu_decoder
//   illegal_o           : pulse in DECODE on unsupported opcode
//   state_o             : current state (debug)
module control_fsm
  import definitions_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        adr_src_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic [1:0]  result_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        illegal_o,
  output ctrl_state_t state_o
);

  ctrl_state_t state, state_nxt;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; op_i only consulted in DECODE and MEMADR
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (mem_ready_i) state_nxt = DECODE;
      DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_R:              state_nxt = EXECUTER;
          OP_I:              state_nxt = EXECUTEI;
          OP_JAL:            state_nxt = JAL;
          OP_BRANCH:         state_nxt = BEQ;
          default:           state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = op_i[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready_i) state_nxt = MEMWB;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: if (mem_ready_i) state_nxt = FETCH;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BEQ:      state_nxt = FETCH;
      JAL:      state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  logic pc_update;
  logic branch;

  // Output decode. Reset overrides everything so no enable or select
  // escapes while rst_i is high, even though state already reads FETCH.
  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = '0;
    alu_src_a_o  = '0;
    alu_src_b_o  = '0;
    alu_op_o     = '0;
    illegal_o    = 1'b0;
    case (state)
      FETCH: begin
        adr_src_o    = 1'b0;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALURESULT;
        ir_write_o   = mem_ready_i;
        pc_update    = mem_ready_i;
      end
      DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
        case (op_i)
          OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH: illegal_o = 1'b0;
          default: illegal_o = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
      end
      MEMREAD: begin
        adr_src_o    = 1'b1;
        result_src_o = RES_ALUOUT;
      end
      MEMWB: begin
        result_src_o = RES_DATA;
        reg_write_o  = 1'b1;
      end
      MEMWRITE: begin
        adr_src_o    = 1'b1;
        result_src_o = RES_ALUOUT;
        mem_write_o  = 1'b1;
      end
      EXECUTER: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_RD2;
        alu_op_o    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a_o = SRCA_RD1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_FUNCT;
      end
      ALUWB: begin
        result_src_o = RES_ALUOUT;
        reg_write_o  = 1'b1;
      end
      BEQ: begin
        alu_src_a_o  = SRCA_RD1;
        alu_src_b_o  = SRCB_RD2;
        alu_op_o     = ALUOP_SUB;
        result_src_o = RES_ALUOUT;
        branch       = 1'b1;
      end
      JAL: begin
        alu_src_a_o  = SRCA_OLDPC;
        alu_src_b_o  = SRCB_FOUR;
        alu_op_o     = ALUOP_ADD;
        result_src_o = RES_ALUOUT;
        pc_update    = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase

    pc_write_o = pc_update | (branch & zero_i);

    if (rst_i) begin
      pc_write_o   = 1'b0;
      adr_src_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = '0;
      alu_src_a_o  = '0;
      alu_src_b_o  = '0;
      alu_op_o     = '0;
      illegal_o    = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: the stimulus process drives one cycle
// of inputs just after each rising edge and queues the hand-computed state
// and output vector for that cycle; the monitor pops and compares on the
// following falling edge.
module tb_control_fsm;
  import definitions_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic        zero;
  logic        rdy;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, src_a, src_b, alu_op;
  ctrl_state_t state;

  control_fsm dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .op_i         (op),
    .zero_i       (zero),
    .mem_ready_i  (rdy),
    .pc_write_o   (pc_write),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .result_src_o (result_src),
    .alu_src_a_o  (src_a),
    .alu_src_b_o  (src_b),
    .alu_op_o     (alu_op),
    .illegal_o    (illegal),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    ctrl_state_t st;
    logic [13:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {pc_write, adr_src, mem_write, ir_write, reg_write,
  //  result_src, src_a, src_b, alu_op, illegal}
  function automatic logic [13:0] ov(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] ao, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, ill};
  endfunction

  task automatic step(input string nm, input logic r, input logic [6:0] o,
                      input logic z, input logic rd,
                      input ctrl_state_t st, input logic [13:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = r;
    op   = o;
    zero = z;
    rdy  = rd;
    x.name = nm;
    x.st   = st;
    x.outs = e;
    exp_q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t x;
    logic [13:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, src_a, src_b, alu_op, illegal};
        n_cmp++;
        if (state !== x.st) begin
          n_bad++;
          $display("FAIL %s state: got %s, want %s", x.name, state.name(), x.st.name());
        end
        n_cmp++;
        if (act !== x.outs) begin
          n_bad++;
          $display("FAIL %s outputs: got %b, want %b", x.name, act, x.outs);
        end
      end
    end
  end

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0000000;

  logic [13:0] o_fetch, o_fetch_wait, o_decode, o_memadr, o_zero;

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; rdy = 1'b1;
    o_fetch      = ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    o_fetch_wait = ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    o_decode     = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    o_memadr     = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    o_zero       = '0;

    // Reset: FETCH with everything forced low despite mem_ready
    step("rst_hold", 1, LW, 0, 1, FETCH, o_zero);

    // lw, ready tied high: 5 cycles
    step("lw_fetch",   0, LW, 0, 1, FETCH,   o_fetch);
    step("lw_decode",  0, LW, 0, 1, DECODE,  o_decode);
    step("lw_memadr",  0, LW, 0, 1, MEMADR,  o_memadr);
    step("lw_memread", 0, LW, 0, 1, MEMREAD, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    step("lw_memwb",   0, LW, 0, 1, MEMWB,   ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));

    // sw with two wait cycles in MEMWRITE, plus one fetch wait
    step("sw_fetchwait", 0, SW, 0, 0, FETCH,    o_fetch_wait);
    step("sw_fetch",     0, SW, 0, 1, FETCH,    o_fetch);
    step("sw_decode",    0, SW, 0, 1, DECODE,   o_decode);
    step("sw_memadr",    0, SW, 0, 1, MEMADR,   o_memadr);
    step("sw_mw1",       0, SW, 0, 0, MEMWRITE, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    step("sw_mw2",       0, SW, 0, 0, MEMWRITE, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    step("sw_mw3",       0, SW, 0, 1, MEMWRITE, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

    // beq taken
    step("beq1_fetch",  0, BQ, 1, 1, FETCH,  o_fetch);
    step("beq1_decode", 0, BQ, 1, 1, DECODE, o_decode);
    step("beq1_taken",  0, BQ, 1, 1, BEQ,    ov(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0));
    // beq not taken
    step("beq0_fetch",  0, BQ, 0, 1, FETCH,  o_fetch);
    step("beq0_decode", 0, BQ, 0, 1, DECODE, o_decode);
    step("beq0_nt",     0, BQ, 0, 1, BEQ,    ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0));

    // R-type
    step("r_fetch",  0, RT, 0, 1, FETCH,    o_fetch);
    step("r_decode", 0, RT, 0, 1, DECODE,   o_decode);
    step("r_exec",   0, RT, 0, 1, EXECUTER, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
    step("r_aluwb",  0, RT, 0, 1, ALUWB,    ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    // I-type
    step("i_fetch",  0, IT, 0, 1, FETCH,    o_fetch);
    step("i_decode", 0, IT, 0, 1, DECODE,   o_decode);
    step("i_exec",   0, IT, 0, 1, EXECUTEI, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0));
    step("i_aluwb",  0, IT, 0, 1, ALUWB,    ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));

    // jal
    step("jal_fetch",  0, JL, 0, 1, FETCH,  o_fetch);
    step("jal_decode", 0, JL, 0, 1, DECODE, o_decode);
    step("jal_jal",    0, JL, 0, 1, JAL,    ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
    step("jal_aluwb",  0, JL, 0, 1, ALUWB,  ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));

    // illegal opcode: 2 cycles, pulse in DECODE
    step("ill_fetch",  0, BAD, 0, 1, FETCH,  o_fetch);
    step("ill_decode", 0, BAD, 0, 1, DECODE, ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 1));

    // lw aborted by reset in MEMREAD
    step("abort_fetch",   0, LW, 0, 1, FETCH,   o_fetch);
    step("abort_decode",  0, LW, 0, 1, DECODE,  o_decode);
    step("abort_memadr",  0, LW, 0, 1, MEMADR,  o_memadr);
    step("abort_memread", 0, LW, 0, 0, MEMREAD, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    step("abort_rst",     1, LW, 1, 1, FETCH,   o_zero);
    step("abort_release", 0, LW, 0, 1, FETCH,   o_fetch);
    step("abort_decode2", 0, LW, 0, 1, DECODE,  o_decode);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
